// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down counter sweep controller.
// Holds the FSM state encoding and the default widths.
package updown_sweep_pkg;

  localparam int W_DEF  = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DWELL_HI,
    DOWN,
    DWELL_LO
  } sweep_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that times the hold at each sweep bound.
// expired marks the cycle whose decrement brings the count to zero.
module dwell_timer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] value,
  output logic          expired
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - DW'(1);
    end
  end

  // A load of N therefore yields exactly N cycles before expired is seen.
  assign expired = (cnt == DW'(1)) && !load;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Drives an external up/down counter through a bounded triangle sweep
// lo -> hi -> hold -> lo -> hold, repeated a programmable number of times.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  lo_bound,
  input  logic [W-1:0]  hi_bound,
  input  logic [DW-1:0] dwell,
  input  logic [7:0]    num_sweeps,
  input  logic [W-1:0]  count_in,
  output logic          enable,
  output logic          up_down,
  output logic          count_load,
  output logic [W-1:0]  load_value,
  output logic          busy,
  output logic          turn,
  output logic          done,
  output logic          err
);

  sweep_state_e  state;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [DW-1:0] dwell_q;
  logic [7:0]    nsw_q;
  logic [7:0]    sweep_cnt;
  logic [7:0]    sweep_nxt;
  logic          at_hi;
  logic          at_lo;
  logic          timer_load;
  logic          timer_expired;

  assign at_hi     = (count_in == hi_q);
  assign at_lo     = (count_in == lo_q);
  assign sweep_nxt = sweep_cnt + 8'd1;

  // Reloading on every bound hit is harmless: the value is only consumed
  // when the FSM actually enters a dwell state.
  assign timer_load = ((state == UP) && at_hi) || ((state == DOWN) && at_lo);

  dwell_timer #(.DW(DW)) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (dwell_q),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      dwell_q   <= '0;
      nsw_q     <= '0;
      sweep_cnt <= '0;
      turn      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      turn <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (lo_bound >= hi_bound) begin
                err <= 1'b1;
              end else begin
                lo_q      <= lo_bound;
                hi_q      <= hi_bound;
                dwell_q   <= dwell;
                nsw_q     <= num_sweeps;
                sweep_cnt <= '0;
                state     <= LOAD;
              end
            end
          end
          LOAD: state <= UP;
          UP: begin
            if (at_hi) begin
              turn  <= 1'b1;
              state <= (dwell_q != '0) ? DWELL_HI : DOWN;
            end
          end
          DWELL_HI: begin
            if (timer_expired) state <= DOWN;
          end
          DOWN: begin
            if (at_lo) begin
              turn      <= 1'b1;
              sweep_cnt <= sweep_nxt;
              // num_sweeps of zero means free-running; sweep_cnt just wraps.
              if ((nsw_q != 8'd0) && (sweep_nxt == nsw_q)) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= (dwell_q != '0) ? DWELL_LO : UP;
              end
            end
          end
          DWELL_LO: begin
            if (timer_expired) state <= UP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    enable  = 1'b0;
    up_down = 1'b0;
    case (state)
      UP: begin
        up_down = 1'b1;
        enable  = !at_hi;
      end
      DOWN: begin
        up_down = 1'b0;
        enable  = !at_lo;
      end
      default: begin
        enable  = 1'b0;
        up_down = 1'b0;
      end
    endcase
  end

  assign count_load = (state == LOAD);
  assign load_value = (state == LOAD) ? lo_q : '0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl driving a behavioural 4-bit counter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] lo_bound = '0;
  logic [3:0] hi_bound = '0;
  logic [7:0] dwell = '0;
  logic [7:0] num_sweeps = '0;
  logic [3:0] count = '0;
  logic       enable, up_down, count_load, busy, turn, done, err;
  logic [3:0] load_value;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Counter: synchronous load overrides enable, no reset of its own.
  always @(posedge clk) begin
    if (count_load)   count <= load_value;
    else if (enable)  count <= up_down ? count + 4'd1 : count - 4'd1;
  end

  updown_sweep_ctrl #(.W(4), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .lo_bound   (lo_bound),
    .hi_bound   (hi_bound),
    .dwell      (dwell),
    .num_sweeps (num_sweeps),
    .count_in   (count),
    .enable     (enable),
    .up_down    (up_down),
    .count_load (count_load),
    .load_value (load_value),
    .busy       (busy),
    .turn       (turn),
    .done       (done),
    .err        (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] lo, input logic [3:0] hi,
                        input logic [7:0] d, input logic [7:0] n);
    lo_bound = lo; hi_bound = hi; dwell = d; num_sweeps = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_checks++;
    if ({enable, up_down, count_load, load_value, busy, turn, done, err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%b required all 0",
               {enable, up_down, count_load, load_value, busy, turn, done, err});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({enable, up_down, count_load, load_value, busy, turn, done, err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%b required all 0",
               {enable, up_down, count_load, load_value, busy, turn, done, err});
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_cnt [8];
    logic [5:0] exp_v;
    exp_cnt = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2};
    launch(4'd2, 4'd5, 8'd0, 8'd1);
    n_checks++;
    if (count_load !== 1'b1 || load_value !== 4'd2 || enable !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load: count_load=%b load_value=%0d enable=%b busy=%b required 1/2/0/1",
               count_load, load_value, enable, busy);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      // {up_down, enable, turn, busy, count_load, done}
      exp_v = {(i < 4), !(i == 3 || i == 7), (i == 4), 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (count !== exp_cnt[i] || {up_down, enable, turn, busy, count_load, done} !== exp_v) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: count=%0d flags=%b required count=%0d flags=%b",
                 i, count, {up_down, enable, turn, busy, count_load, done}, exp_cnt[i], exp_v);
      end
    end
    step();
    n_checks++;
    if (done !== 1'b1 || turn !== 1'b1 || busy !== 1'b0 || count !== 4'd2 || enable !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b turn=%b busy=%b count=%0d enable=%b required 1/1/0/2/0",
               done, turn, busy, count, enable);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || turn !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: done=%b turn=%b busy=%b required 0/0/0", done, turn, busy);
    end
  endtask

  task automatic test_dwell();
    int done_idx = -1;
    int turns = 0;
    int hold15 = 0;
    int hold0 = 0;
    int hi_start0 = -1;
    int hi_start1 = -1;
    logic prev_hold = 1'b0;
    logic cur_hold;
    launch(4'd0, 4'd15, 8'd3, 8'd2);
    for (int i = 0; i < 200; i++) begin
      step();
      if (turn) turns++;
      cur_hold = (count == 4'd15) && !enable;
      if (cur_hold) hold15++;
      if (cur_hold && !prev_hold) begin
        if (hi_start0 < 0) hi_start0 = i;
        else if (hi_start1 < 0) hi_start1 = i;
      end
      prev_hold = cur_hold;
      if (busy && count == 4'd0 && !enable) hold0++;
      if (done) begin
        done_idx = i;
        break;
      end
    end
    n_checks++;
    if (done_idx !== 73) begin
      n_fail++;
      $display("FAIL dwell_done_cycle: done at cycle %0d required 73", done_idx);
    end
    n_checks++;
    if (hold15 !== 8) begin
      n_fail++;
      $display("FAIL dwell_hold_hi: held cycles at 15=%0d required 8 (4 per sweep)", hold15);
    end
    n_checks++;
    if (hold0 !== 5) begin
      n_fail++;
      $display("FAIL dwell_hold_lo: held cycles at 0=%0d required 5", hold0);
    end
    n_checks++;
    if (hi_start1 - hi_start0 !== 38 || hi_start0 !== 15) begin
      n_fail++;
      $display("FAIL dwell_period: hi holds start at %0d,%0d required 15,53", hi_start0, hi_start1);
    end
    n_checks++;
    if (turns !== 4) begin
      n_fail++;
      $display("FAIL dwell_turns: turn pulses=%0d required 4", turns);
    end
    step();
  endtask

  task automatic test_err();
    logic [3:0] los [2];
    logic [3:0] his [2];
    los = '{4'd7, 4'd9};
    his = '{4'd7, 4'd3};
    for (int k = 0; k < 2; k++) begin
      launch(los[k], his[k], 8'd0, 8'd1);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || count_load !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse%0d: err=%b busy=%b count_load=%b required 1/0/0",
                 k, err, busy, count_load);
      end
      step();
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0 || count_load !== 1'b0) begin
        n_fail++;
        $display("FAIL err_after%0d: err=%b busy=%b count_load=%b required 0/0/0",
                 k, err, busy, count_load);
      end
    end
  endtask

  task automatic test_free_run();
    int turns = 0;
    int dones = 0;
    launch(4'd1, 4'd3, 8'd0, 8'd0);
    // 6-cycle period, turn every 3 cycles starting at cycle 3; >256 sweeps
    for (int i = 0; i < 1602; i++) begin
      step();
      if (turn) turns++;
      if (done) dones++;
    end
    n_checks++;
    if (turns !== 533 || dones !== 0) begin
      n_fail++;
      $display("FAIL free_run: turns=%0d dones=%0d required 533/0", turns, dones);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || enable !== 1'b0 || turn !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL free_run_stop: busy=%b enable=%b turn=%b done=%b required 0/0/0/0",
               busy, enable, turn, done);
    end
  endtask

  task automatic test_async_reset();
    launch(4'd4, 4'd10, 8'd0, 8'd1);
    repeat (10) step();
    n_checks++;
    if (count !== 4'd8 || busy !== 1'b1 || up_down !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_pre: count=%0d busy=%b up_down=%b required 8/1/0", count, busy, up_down);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({enable, up_down, count_load, load_value, busy, turn, done, err} !== 11'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: outputs=%b required all 0",
               {enable, up_down, count_load, load_value, busy, turn, done, err});
    end
    #1 rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || count !== 4'd8) begin
      n_fail++;
      $display("FAIL areset_after: busy=%b count=%0d required 0/8", busy, count);
    end
    launch(4'd1, 4'd2, 8'd0, 8'd1);
    n_checks++;
    if (count_load !== 1'b1 || load_value !== 4'd1) begin
      n_fail++;
      $display("FAIL areset_reload: count_load=%b load_value=%0d required 1/1", count_load, load_value);
    end
    step();
    n_checks++;
    if (count !== 4'd1) begin
      n_fail++;
      $display("FAIL areset_reload_count: count=%0d required 1", count);
    end
    repeat (6) step();
  endtask

  task automatic test_busy_start();
    int max_c = 0;
    int min_c = 15;
    int loads = 0;
    logic seen_done = 1'b0;
    launch(4'd3, 4'd6, 8'd0, 8'd1);
    step();
    lo_bound = 4'd0; hi_bound = 4'd15; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      start = 1'b0;
      if (count_load) loads++;
      if (busy || done) begin
        if (int'(count) > max_c) max_c = int'(count);
        if (int'(count) < min_c) min_c = int'(count);
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen_done !== 1'b1 || max_c !== 6 || min_c !== 3 || loads !== 0) begin
      n_fail++;
      $display("FAIL busy_start: done=%b max=%0d min=%0d reloads=%0d required 1/6/3/0",
               seen_done, max_c, min_c, loads);
    end
    step();
    lo_bound = 4'd2; hi_bound = 4'd5; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count_load !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle: busy=%b count_load=%b err=%b required 0/0/0",
               busy, count_load, err);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || count_load !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle2: busy=%b count_load=%b required 0/0", busy, count_load);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dwell();
    test_err();
    test_free_run();
    test_async_reset();
    test_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Controller at the command end of the team's 4-bit up/down counter interface. It generates `enable`, `up_down`, `count_load` and `load_value` for a `counter` instance and reads back its `count`. From those it produces a bounded triangle sweep: load `lo`, count up to `hi`, hold, count down to `lo`, hold, and repeat. It sits between a host start/stop interface and the counter, so the counter needs no sweep logic of its own.

## Interface
- `W`, 4: counter width; matches counter `count`/`load_value`.
- `DW`, 8: dwell counter width.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin sweep when idle; ignored while busy.
- `stop` input 1: abort; has priority over everything except `rst`.
- `lo_bound` input W: lower sweep bound, latched on accepted `start`.
- `hi_bound` input W: upper sweep bound, latched on accepted `start`.
- `dwell` input DW: extra hold cycles at each bound, latched on `start`.
- `num_sweeps` input 8: full lo→hi→lo sweeps to run; 0 = run until `stop`.
- `count_in` input W: counter `count` output.
- `enable` output 1: to counter `enable`.
- `up_down` output 1: to counter `up_down`; 1 = up, 0 = down.
- `count_load` output 1: to counter `count_load`.
- `load_value` output W: to counter `load_value`.
- `busy` output 1: high in every state except IDLE.
- `turn` output 1: one-cycle pulse when a bound is reached.
- `done` output 1: one-cycle pulse on sweep-count completion.
- `err` output 1: one-cycle pulse when `start` is rejected.

## Operation
- Counter contract: synchronous load that overrides enable; when enabled it counts by 1 per clock in the `up_down` direction.
- FSM states: IDLE, LOAD, UP, DWELL_HI, DOWN, DWELL_LO.
- IDLE: all outputs 0. On `start`:
  - if `lo_bound >= hi_bound`: pulse `err`, stay IDLE;
  - otherwise latch `lo`, `hi`, `dwell`, `num_sweeps`, clear `sweep_cnt`, go to LOAD.
- LOAD (1 cycle): `count_load=1`, `load_value=lo`, `enable=0`. Next state is UP.
- UP:
  - `up_down=1`, `enable=(count_in!=hi)`.
  - When `count_in==hi`: pulse `turn`; next state is DWELL_HI if `dwell!=0`, else DOWN.
- DWELL_HI: `enable=0` for exactly `dwell` cycles, then DOWN.
- DOWN:
  - `up_down=0`, `enable=(count_in!=lo)`.
  - When `count_in==lo`: pulse `turn` and increment `sweep_cnt`.
  - If `num_sweeps!=0` and the incremented `sweep_cnt==num_sweeps`: pulse `done`, go to IDLE.
  - Otherwise go to DWELL_LO, or straight to UP if `dwell==0`.
- DWELL_LO: `enable=0` for `dwell` cycles, then UP.
- Net hold at each bound is `dwell+1` cycles: the compare cycle plus the dwell cycles.
- `stop` sampled high in any state: next state IDLE; no `done` and no `turn` that cycle. Asserting `start` and `stop` together from IDLE stays in IDLE.
- `sweep_cnt` is 8-bit. With `num_sweeps=0` it wraps 255→0 without effect.
- `count_in` outside `[lo,hi]` while in UP/DOWN (external corruption): counting continues modulo 2^W until the bound compare hits. This is not an error.

## Timing
- Reset values: state IDLE, every output 0, `sweep_cnt` 0, latched bounds 0.
- `enable` and `up_down` are combinational decodes of the state register and `count_in`. `count_load`, `load_value`, `busy`, `turn`, `done` and `err` are decoded from state and registers only. There is no combinational path from `start`/`stop` to any output.
- `start` accepted at edge N: LOAD is in cycle N+1, and `count_in==lo` is visible in cycle N+2 (first UP cycle).
- `rst` asserted mid-sweep: outputs go to 0 immediately (asynchronous). The counter keeps its value. After release the block is in IDLE.
- Sweep period with `dwell=d`: 2·(hi−lo) + 2·(d+1) cycles.

## Structure
- Package `updown_sweep_pkg`: state enum `sweep_state_e` and width constants `W_DEF`/`DW_DEF`.
- Sub-module `dwell_timer`:
  - inputs: load, value;
  - outputs: expired;
  - behaviour: down-counter that asserts `expired` on the cycle its value reaches 0.
  - Instantiated once and shared by DWELL_HI and DWELL_LO.
- Bench instantiates this block driving a real `counter`.

## Test plan
- Reset, then `start` with lo=2, hi=5, dwell=0, num_sweeps=1:
  - `count_load` high 1 cycle with `load_value=2`;
  - count sequence 2,3,4,5,5,4,3,2;
  - `turn` pulses at count=5 and count=2;
  - `done` in the final count=2 cycle, then `busy=0`.
- lo=0, hi=15, dwell=3, num_sweeps=2: count holds 4 cycles at 15 and at 0; period 38 cycles; `done` after 2 sweeps.
- `start` with lo=7, hi=7 → `err` pulse, `busy` stays 0, no `count_load`. With lo=9, hi=3 → same response.
- num_sweeps=0, lo=1, hi=3: more than 300 `turn` pulses with no `done`; `stop` ends the run; `busy=0` and `enable=0` the next cycle.
- `rst` pulsed asynchronously between edges during DOWN: all outputs are 0 before the next edge; a later `start` reloads `lo`.
- `start` while busy is ignored: bounds stay unchanged. `start` and `stop` in the same IDLE cycle → stays IDLE.
